// File: rtl/radix2_bf_1.sv
// ---------------------------------------------------------------------------
// radix2_bf_1
//   Final-stage (delay-1) radix-2 single-path delay-feedback butterfly of the
//   64-point FFT. The one-deep delay line lives outside this block.
//   The block writes fb_r/fb_i into it and reads the value back one cycle
//   later on dly_r/dly_i.
//
//   Even samples (phase 0) are parked in the delay line. Odd samples
//   (phase 1) produce the pair sum straight away. The pair difference is
//   written back into the delay line. It is emitted on the next even accept,
//   or by a one-cycle FLUSH when the input stream stops.
//
//   Configuration macro:
//     BF1_SAT_EN : if defined, sum/difference saturate to the 24-bit signed
//                  range. If undefined, they wrap (low 24 bits kept).
//
//   Ports
//     clk             in   rising-edge clock
//     rst             in   asynchronous active-high reset
//     in_valid        in   din carries a sample this cycle
//     din_r/din_i     in   new sample, signed 24b
//     dly_r/dly_i     in   delay-line output (last cycle's fb)
//     fb_r/fb_i       out  delay-line write value, combinational
//     dout_r/dout_i   out  butterfly output, registered
//     out_valid       out  dout valid, registered
//     out_last        out  dout is output 63 of the frame, registered
// ---------------------------------------------------------------------------
module radix2_bf_1 (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [23:0] din_r,
  input  logic signed [23:0] din_i,
  input  logic signed [23:0] dly_r,
  input  logic signed [23:0] dly_i,
  output logic signed [23:0] fb_r,
  output logic signed [23:0] fb_i,
  output logic signed [23:0] dout_r,
  output logic signed [23:0] dout_i,
  output logic               out_valid,
  output logic               out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         in_cnt_q, in_cnt_d;
  logic [5:0]         out_cnt_q, out_cnt_d;
  logic               pend_q, pend_d;
  logic signed [23:0] dout_r_q, dout_r_d;
  logic signed [23:0] dout_i_q, dout_i_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;

  logic               phase;
  logic signed [24:0] sum_r_w, sum_i_w, dif_r_w, dif_i_w;
  logic signed [23:0] sum_r, sum_i, dif_r, dif_i;

  // Bring a 25-bit sum/difference back into 24 bits.
  function automatic logic signed [23:0] reduce25(input logic signed [24:0] v);
    logic signed [23:0] r;
`ifdef BF1_SAT_EN
    // Top two bits disagree only when the value is outside the 24-bit range.
    if (v[24] != v[23])
      r = v[24] ? 24'sh800000 : 24'sh7FFFFF;
    else
      r = v[23:0];
`else
    r = v[23:0];
`endif
    return r;
  endfunction

  assign phase = in_cnt_q[0];

  // Full-precision sum and difference. x0 is the delay-line output and x1
  // is the new sample.
  assign sum_r_w = {dly_r[23], dly_r} + {din_r[23], din_r};
  assign sum_i_w = {dly_i[23], dly_i} + {din_i[23], din_i};
  assign dif_r_w = {dly_r[23], dly_r} - {din_r[23], din_r};
  assign dif_i_w = {dly_i[23], dly_i} - {din_i[23], din_i};

  assign sum_r = reduce25(sum_r_w);
  assign sum_i = reduce25(sum_i_w);
  assign dif_r = reduce25(dif_r_w);
  assign dif_i = reduce25(dif_i_w);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (in_valid) state_d = RUN;
      // A stall on an even boundary with a difference still parked in the
      // delay line drains it through FLUSH. A stall mid-pair just waits.
      RUN:   if (!in_valid && pend_q && !phase) state_d = FLUSH;
      // The next sample may arrive in the same cycle as the flush.
      FLUSH: state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    fb_r      = dly_r;   // default: recirculate, the delay line keeps its value
    fb_i      = dly_i;
    dout_r_d  = dout_r_q;
    dout_i_d  = dout_i_q;
    vld_d     = 1'b0;
    pend_d    = pend_q;
    in_cnt_d  = in_cnt_q;

    if (in_valid) begin
      in_cnt_d = in_cnt_q + 6'd1;
      if (!phase) begin
        // Even sample: park x0 and emit the difference parked by the
        // previous pair, if there is one.
        fb_r     = din_r;
        fb_i     = din_i;
        dout_r_d = dly_r;
        dout_i_d = dly_i;
        vld_d    = pend_q;
        pend_d   = 1'b0;
      end else begin
        // Odd sample: emit the sum now and park the difference.
        fb_r     = dif_r;
        fb_i     = dif_i;
        dout_r_d = sum_r;
        dout_i_d = sum_i;
        vld_d    = 1'b1;
        pend_d   = 1'b1;
      end
    end else if (state_q == FLUSH) begin
      dout_r_d = dly_r;
      dout_i_d = dly_i;
      vld_d    = 1'b1;
      pend_d   = 1'b0;
    end

    out_cnt_d = vld_d ? out_cnt_q + 6'd1 : out_cnt_q;
    last_d    = vld_d && (out_cnt_q == 6'd63);
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      pend_q    <= 1'b0;
      dout_r_q  <= '0;
      dout_i_q  <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      pend_q    <= pend_d;
      dout_r_q  <= dout_r_d;
      dout_i_q  <= dout_i_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
    end
  end

  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;
  assign out_valid = vld_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_radix2_bf_1.sv
module tb_radix2_bf_1;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [23:0] din_r = '0, din_i = '0;
  logic signed [23:0] dly_r = '0, dly_i = '0;
  logic signed [23:0] fb_r, fb_i, dout_r, dout_i;
  logic               out_valid, out_last;

  int checks = 0;
  int errors = 0;

  radix2_bf_1 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i), .dly_r(dly_r), .dly_i(dly_i),
    .fb_r(fb_r), .fb_i(fb_i), .dout_r(dout_r), .dout_i(dout_i),
    .out_valid(out_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // External one-deep delay line.
  always @(posedge clk) begin
    dly_r <= fb_r;
    dly_i <= fb_i;
  end

  // Reference model: pairs in arrival order. A completed pair queues its
  // sum and then its difference. Outputs must appear in exactly that order.
  typedef struct { int r; int i; } cplx_t;
  cplx_t expq[$];
  bit    mph;
  int    x0r, x0i;
  int    ocnt;
  int    tot_out;
  logic signed [31:0] fb_r_s, fb_i_s;

  function automatic int red(input int v);
`ifdef BF1_SAT_EN
    if (v > 8388607)  return 8388607;
    if (v < -8388608) return -8388608;
    return v;
`else
    int w;
    w = v & 32'h00FF_FFFF;
    if (w >= 8388608) w = w - 16777216;
    return w;
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    expq.delete();
    mph = 1'b0;
    ocnt = 0;
    tot_out = 0;
  endtask

  // One clock cycle. Drive the inputs, capture fb before the edge, then
  // score the registered outputs after the edge.
  task automatic step(input bit v, input int r, input int i);
    cplx_t e;
    in_valid = v;
    din_r = r[23:0];
    din_i = i[23:0];
    #1;
    fb_r_s = fb_r;
    fb_i_s = fb_i;
    if (v) begin
      if (!mph) begin
        x0r = r; x0i = i;
      end else begin
        expq.push_back('{red(x0r + r), red(x0i + i)});
        expq.push_back('{red(x0r - r), red(x0i - i)});
      end
      mph = ~mph;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("dout_r", dout_r, e.r);
        chk("dout_i", dout_i, e.i);
        chk("out_last", out_last, (ocnt == 63) ? 1 : 0);
        ocnt = (ocnt + 1) % 64;
        tot_out++;
      end
    end else begin
      chk("out_valid_known", out_valid, 0);
      chk("out_last_idle", out_last, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_dout_r", dout_r, 0);
    chk("rst_dout_i", dout_i, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    #2;

    // Basic pair followed by a flush
    do_reset();
    step(1, 100, -20);
    chk("p1_no_out", out_valid, 0);
    step(1, 30, 5);
    chk("p1_fb_r", fb_r_s, 70);
    chk("p1_fb_i", fb_i_s, -25);
    chk("p1_sum_v", out_valid, 1);
    chk("p1_sum_r", dout_r, 130);
    chk("p1_sum_i", dout_i, -15);
    step(0, 0, 0);
    chk("p1_gap_v", out_valid, 0);
    step(0, 0, 0);
    chk("p1_flush_v", out_valid, 1);
    chk("p1_diff_r", dout_r, 70);
    chk("p1_diff_i", dout_i, -25);
    step(0, 0, 0);
    chk("p1_idle_v", out_valid, 0);
    chk("p1_drain", expq.size(), 0);

    // Full 64-sample frame; output 63 is produced by the flush
    do_reset();
    for (int k = 0; k < 64; k++) step(1, k, 0);
    chk("fr_count_pre", tot_out, 63);
    chk("fr_last_pre", out_last, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("fr_flush_v", out_valid, 1);
    chk("fr_flush_last", out_last, 1);
    chk("fr_flush_diff", dout_r, -1);
    idle(2);
    chk("fr_count", tot_out, 64);
    chk("fr_drain", expq.size(), 0);

    // Mid-pair stall: the delay line keeps x0
    do_reset();
    step(1, 10, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      chk("gap_fb_r", fb_r_s, 10);
      chk("gap_fb_i", fb_i_s, 0);
      chk("gap_no_out", out_valid, 0);
    end
    step(1, 4, 0);
    chk("gap_sum", dout_r, 14);
    idle(2);
    chk("gap_diff", dout_r, 6);
    idle(1);
    chk("gap_drain", expq.size(), 0);

    // Overflow at the top of the range
    do_reset();
    step(1, 8388607, 0);
    step(1, 1, 0);
`ifdef BF1_SAT_EN
    chk("ovf_sum", dout_r, 8388607);
`else
    chk("ovf_sum", dout_r, -8388608);
`endif
    step(1, -8388608, 8388607);
    step(1, 1, -1);
    idle(3);
    chk("ovf_drain", expq.size(), 0);

    // Reset after pair 5, then a fresh frame
    do_reset();
    for (int k = 0; k < 12; k++) step(1, k * 3, -k);
    chk("mid_out_v", out_valid, 1);
    do_reset();
    for (int k = 0; k < 64; k++) step(1, 1000 - k, k);
    idle(3);
    chk("rf_count", tot_out, 64);
    chk("rf_drain", expq.size(), 0);

    // New sample arrives in the FLUSH cycle
    do_reset();
    step(1, 7, 3);
    step(1, 2, 1);
    step(0, 0, 0);
    step(1, 50, -5);
    chk("ff_v", out_valid, 1);
    chk("ff_diff_r", dout_r, 5);
    chk("ff_diff_i", dout_i, 2);
    step(1, 20, 5);
    chk("ff_sum_r", dout_r, 70);
    chk("ff_sum_i", dout_i, 0);
    idle(3);
    chk("ff_drain", expq.size(), 0);

    // Random samples with random stalls
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [23:0] tr, ti;
      tr = $urandom;
      ti = $urandom;
      step($urandom_range(0, 3) != 0, int'($signed(tr)), int'($signed(ti)));
    end
    idle(4);
    chk("rnd_drain", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
